// File: rtl/beat_burst_bridge_pkg.sv
// Shared constants for the tester-to-DDR3 beat/burst bridge:
// command encodings, controller data width and FSM state codes.
package beat_burst_bridge_pkg;

    localparam int DATA_W = 128;

    localparam logic [2:0] CMD_WR = 3'h0;
    localparam logic [2:0] CMD_RD = 3'h1;

    // Plain constants rather than an enum so older tools can read the state register directly
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WR_COLLECT = 3'd1;
    localparam logic [2:0] ST_WR_ISSUE   = 3'd2;
    localparam logic [2:0] ST_RD_ISSUE   = 3'd3;
    localparam logic [2:0] ST_RD_WAIT    = 3'd4;
    localparam logic [2:0] ST_RD_SERIAL  = 3'd5;

endpackage

// File: rtl/beat_burst_bridge_if.sv
// Bus bundle between the DDR tester beat port and the DDR3 controller native port.
// The bridge uses the slave view; whatever drives tester and controller uses master.
interface beat_burst_bridge_if
    import beat_burst_bridge_pkg::*;
#(
    parameter int ADDR_W = 27,
    parameter int BEAT_W = 16
);
    logic [ADDR_W-1:0] app_addr;
    logic              app_wr_valid;
    logic              app_wr_rdy;
    logic [BEAT_W-1:0] app_wr_payload;
    logic              app_rd_rdy;
    logic              app_rd_valid;
    logic [BEAT_W-1:0] app_rd_payload;

    logic [2:0]        ctl_cmd;
    logic              ctl_cmd_en;
    logic [ADDR_W-1:0] ctl_addr;
    logic              ctl_cmd_rdy;
    logic [DATA_W-1:0] ctl_wdata;
    logic              ctl_wdata_en;
    logic              ctl_wdata_end;
    logic              ctl_wdf_rdy;
    logic [DATA_W-1:0] ctl_rd_data;
    logic              ctl_rd_valid;

    modport master (
        output app_addr, app_wr_valid, app_wr_payload, app_rd_rdy,
        output ctl_cmd_rdy, ctl_wdf_rdy, ctl_rd_data, ctl_rd_valid,
        input  app_wr_rdy, app_rd_valid, app_rd_payload,
        input  ctl_cmd, ctl_cmd_en, ctl_addr, ctl_wdata, ctl_wdata_en, ctl_wdata_end
    );

    modport slave (
        input  app_addr, app_wr_valid, app_wr_payload, app_rd_rdy,
        input  ctl_cmd_rdy, ctl_wdf_rdy, ctl_rd_data, ctl_rd_valid,
        output app_wr_rdy, app_rd_valid, app_rd_payload,
        output ctl_cmd, ctl_cmd_en, ctl_addr, ctl_wdata, ctl_wdata_en, ctl_wdata_end
    );

endinterface

// File: rtl/beat_burst_bridge_beat_serdes.sv
// Wide data register plus beat counter, shared by write packing (shift in)
// and read unpacking (parallel load, then shift out).
module beat_serdes #(
    parameter int BEAT_W = 16,
    parameter int BEATS  = 8,
    localparam int WIDE_W = BEAT_W * BEATS,
    localparam int CNT_W  = $clog2(BEATS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift_in,
    input  logic              shift_out,
    input  logic [WIDE_W-1:0] din,
    input  logic [BEAT_W-1:0] beat_in,
    output logic [WIDE_W-1:0] dout,
    output logic [BEAT_W-1:0] beat_out,
    output logic              last
);
    logic [WIDE_W-1:0] data_q;
    logic [CNT_W-1:0]  cnt_q;

    // Beats enter at the top and move down, so after BEATS shifts beat 0 sits in the low slice
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            data_q <= din;
            cnt_q  <= '0;
        end else if (shift_in) begin
            data_q <= {beat_in, data_q[WIDE_W-1:BEAT_W]};
            cnt_q  <= last ? '0 : cnt_q + 1'b1;
        end else if (shift_out) begin
            data_q <= {{BEAT_W{1'b0}}, data_q[WIDE_W-1:BEAT_W]};
            cnt_q  <= last ? '0 : cnt_q + 1'b1;
        end
    end

    assign dout     = data_q;
    assign beat_out = data_q[BEAT_W-1:0];
    assign last     = (cnt_q == CNT_W'(BEATS - 1));

endmodule

// File: rtl/beat_burst_bridge.sv
// Converts 8-beat 16-bit tester bursts into single 128-bit DDR3 controller
// commands, with a sticky read-timeout flag so the tester can never hang.
module beat_burst_bridge
    import beat_burst_bridge_pkg::*;
#(
    parameter int ADDR_W     = 27,
    parameter int BEAT_W     = 16,
    parameter int BEATS      = 8,
    parameter int RD_TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    beat_burst_bridge_if.slave  bus,
    output logic                busy,
    output logic                rd_timeout_err
);
    localparam int TMO_W = $clog2(RD_TIMEOUT);

    logic [2:0]          state_q;
    logic [2:0]          state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [TMO_W-1:0]    tmo_q;
    logic                err_q;
    logic                tmo_hit;

    logic                sd_load;
    logic                sd_shift_in;
    logic                sd_shift_out;
    logic [DATA_W-1:0]   sd_din;
    logic [DATA_W-1:0]   sd_dout;
    logic [BEAT_W-1:0]   sd_beat_out;
    logic                sd_last;

    beat_serdes #(
        .BEAT_W (BEAT_W),
        .BEATS  (BEATS)
    ) u_serdes (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (sd_load),
        .shift_in (sd_shift_in),
        .shift_out(sd_shift_out),
        .din      (sd_din),
        .beat_in  (bus.app_wr_payload),
        .dout     (sd_dout),
        .beat_out (sd_beat_out),
        .last     (sd_last)
    );

    assign tmo_hit = (tmo_q == TMO_W'(RD_TIMEOUT - 1));

    always_comb begin
        state_d      = state_q;
        sd_load      = 1'b0;
        sd_shift_in  = 1'b0;
        sd_shift_out = 1'b0;
        sd_din       = '0;
        case (state_q)
            ST_IDLE: begin
                // Write wins a tie; the simultaneous read request is simply dropped
                if (bus.app_wr_valid)
                    state_d = ST_WR_COLLECT;
                else if (bus.app_rd_rdy)
                    state_d = ST_RD_ISSUE;
            end
            ST_WR_COLLECT: begin
                sd_shift_in = 1'b1;
                if (sd_last)
                    state_d = ST_WR_ISSUE;
            end
            ST_WR_ISSUE: begin
                if (bus.ctl_cmd_rdy && bus.ctl_wdf_rdy)
                    state_d = ST_IDLE;
            end
            ST_RD_ISSUE: begin
                if (bus.ctl_cmd_rdy)
                    state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                // A timed-out read still returns a full burst of zeros to release the tester
                if (bus.ctl_rd_valid) begin
                    sd_load = 1'b1;
                    sd_din  = bus.ctl_rd_data;
                    state_d = ST_RD_SERIAL;
                end else if (tmo_hit) begin
                    sd_load = 1'b1;
                    state_d = ST_RD_SERIAL;
                end
            end
            ST_RD_SERIAL: begin
                sd_shift_out = 1'b1;
                if (sd_last)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && (bus.app_wr_valid || bus.app_rd_rdy))
                addr_q <= bus.app_addr;
            if (state_q == ST_RD_ISSUE)
                tmo_q <= '0;
            else if (state_q == ST_RD_WAIT && !tmo_hit)
                tmo_q <= tmo_q + 1'b1;
            if (state_q == ST_RD_WAIT && !bus.ctl_rd_valid && tmo_hit)
                err_q <= 1'b1;
        end
    end

    assign bus.app_wr_rdy     = (state_q == ST_WR_COLLECT);
    assign bus.app_rd_valid   = (state_q == ST_RD_SERIAL);
    assign bus.app_rd_payload = bus.app_rd_valid ? sd_beat_out : '0;

    assign bus.ctl_cmd        = (state_q == ST_RD_ISSUE) ? CMD_RD : CMD_WR;
    assign bus.ctl_cmd_en     = (state_q == ST_WR_ISSUE) || (state_q == ST_RD_ISSUE);
    assign bus.ctl_addr       = addr_q;
    assign bus.ctl_wdata      = sd_dout;
    assign bus.ctl_wdata_en   = (state_q == ST_WR_ISSUE);
    assign bus.ctl_wdata_end  = (state_q == ST_WR_ISSUE);

    assign busy           = (state_q != ST_IDLE);
    assign rd_timeout_err = err_q;

endmodule

// File: doc/beat_burst_bridge.md
Name: beat_burst_bridge

Overview:
- Sits directly downstream of the DDR tester and upstream of the DDR3 controller IP user port.
- Converts the tester's 16-bit, 8-beat serial burst port (address plus valid/rdy pulses) into single 128-bit native controller commands.
- Write bursts are packed into one 128-bit word; each 128-bit read is returned to the tester as 8 serial beats.
- Also provides a sticky read-timeout flag and a busy status.

Parameters:
- ADDR_W, 27, byte/beat address width shared by both sides.
- BEAT_W, 16, tester beat width.
- BEATS, 8, beats per burst (BEAT_W*BEATS = 128 = controller data width).
- RD_TIMEOUT, 4096, cycles to wait for controller read data before flagging an error.

Ports:
- clk  in  1  system clock (80 MHz)
- rst_n  in  1  reset
- app_addr  in  ADDR_W  tester burst address; sampled at request
- app_wr_valid  in  1  tester write-burst request pulse
- app_wr_rdy  out  1  beat accept strobe; payload sampled while high
- app_wr_payload  in  BEAT_W  write beat
- app_rd_rdy  in  1  tester read-burst request pulse
- app_rd_valid  out  1  read beat strobe
- app_rd_payload  out  BEAT_W  read beat
- ctl_cmd  out  3  3'h0 write, 3'h1 read
- ctl_cmd_en  out  1  command strobe
- ctl_addr  out  ADDR_W  command address
- ctl_cmd_rdy  in  1  controller can accept a command
- ctl_wdata  out  128  write data
- ctl_wdata_en  out  1  write data strobe
- ctl_wdata_end  out  1  last write word (always equal to ctl_wdata_en)
- ctl_wdf_rdy  in  1  write FIFO ready
- ctl_rd_data  in  128  read data
- ctl_rd_valid  in  1  read data strobe
- busy  out  1  high in every state except IDLE
- rd_timeout_err  out  1  sticky; cleared only by reset

Behaviour:
- Reset rst_n is asynchronous, active-low; clock is clk.
- Reset values: all outputs are 0, ctl_cmd is 3'h0, FSM is IDLE, beat counter is 0, pack/unpack registers are 0.
- Reset mid-operation aborts immediately. No partial command is issued afterwards.

FSM states: IDLE, WR_COLLECT, WR_ISSUE, RD_ISSUE, RD_WAIT, RD_SERIAL.
- IDLE:
  - On app_wr_valid: latch app_addr and go to WR_COLLECT.
  - Otherwise, on app_rd_rdy: latch app_addr and go to RD_ISSUE.
  - If both arrive in the same cycle, write wins and the read request is dropped.
  - ctl_rd_valid in IDLE is ignored.
- WR_COLLECT:
  - app_wr_rdy is high for exactly BEATS consecutive cycles, the first one cycle after the request.
  - Beat k (k = 0..7) is stored in pack[k*16 +: 16]. Beat 0 lands in bits [15:0].
  - After beat 7, app_wr_rdy drops and the FSM goes to WR_ISSUE.
- WR_ISSUE:
  - ctl_cmd_en, ctl_wdata_en and ctl_wdata_end are asserted together (cmd 3'h0, latched address, pack data).
  - They stay asserted until a cycle where ctl_cmd_rdy and ctl_wdf_rdy are both high. That cycle is the handshake.
  - Strobes deassert the next cycle and the FSM returns to IDLE.
- RD_ISSUE:
  - cmd 3'h1 with ctl_cmd_en held until ctl_cmd_rdy is high.
  - Then go to RD_WAIT and clear the timeout counter.
- RD_WAIT:
  - On ctl_rd_valid: latch ctl_rd_data and go to RD_SERIAL.
  - On timeout (counter reaches RD_TIMEOUT-1): set rd_timeout_err, load 128'h0 as data, go to RD_SERIAL. The tester is therefore never hung.
- RD_SERIAL:
  - app_rd_valid is high for exactly BEATS consecutive cycles.
  - app_rd_payload = data[k*16 +: 16] on the k-th valid cycle.
  - Then return to IDLE.
- Requests arriving while busy are ignored and not queued.
- Minimum write latency: request to ctl_cmd_en is 9 cycles.
- Minimum read latency: request to ctl_cmd_en is 1 cycle; ctl_rd_valid to first app_rd_valid is 1 cycle.
- Address is passed through unmodified. Wrap-around is the tester's responsibility.

Decomposition:
- Shared package holds:
  - command encodings CMD_WR = 3'h0, CMD_RD = 3'h1;
  - FSM state localparams;
  - DATA_W = 128.
- One natural sub-module: beat_serdes. It holds the 128-bit register and 3-bit beat counter, with load-parallel, shift-in-beat and shift-out-beat controls. It is used for both packing and unpacking.

Test Plan:
- Write burst at 0x0000000, beats 0x5A01 repeated → after 8 wr_rdy cycles: ctl_cmd_en with cmd 0, ctl_addr 0, ctl_wdata = {8{16'h5A01}}, ctl_wdata_end = 1.
- Write of beats 0x0001..0x0008 at 0x4000000, ctl_cmd_rdy held low 5 cycles → strobes held 5 cycles; ctl_wdata = 128'h0008_0007_..._0001; exactly one handshake.
- Read at 0x0000008; controller returns 128'h0123_4567_890A_BCDE_FEDC_BA98_7654_3210 after 20 cycles → 8 app_rd_valid beats 0x3210, 0x7654, ..., 0x0123 in order.
- Simultaneous app_wr_valid and app_rd_rdy in IDLE → only a write command is issued; no read command appears.
- Controller never returns read data → after 4096 cycles rd_timeout_err = 1 and 8 beats of 0x0000 are returned; busy falls.
- rst_n asserted during WR_ISSUE with ctl_cmd_rdy low → all outputs 0 asynchronously; no command after release; a new write completes normally.
